// File: rtl/ebpc_pkg.sv
// Shared encoder-side constants for the DBX/DBP block encoder and the
// blocks that feed it.
package ebpc_pkg;

  localparam int BLOCK_SIZE = 8;
  localparam int DATA_W     = 8;
  localparam int N_REQ_MAX  = 16;

  typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;

endpackage

// File: rtl/dbx_enc_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr (wrapping), plus a found flag.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] id,
  output logic           found
);

  logic [IDW-1:0] idx;

  always_comb begin
    id    = '0;
    found = 1'b0;
    idx   = '0;
    // Scan from the farthest slot back to ptr so the nearest request wins.
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        id    = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbx_enc_arb.sv
// Block-granular round-robin arbiter in front of the DBX/DBP encoder: a grant
// lasts one full encoder block, short tails are zero-padded, then flushed.
module dbx_enc_arb
  import ebpc_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic signed [DATA_W-1:0] data_i [N_REQ],
  input  logic [N_REQ-1:0]         vld_i,
  input  logic [N_REQ-1:0]         last_i,
  output logic [N_REQ-1:0]         rdy_o,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     vld_o,
  input  logic                     rdy_i,
  output logic                     flush_o,
  input  logic                     enc_idle_i,
  output logic [$clog2(N_REQ)-1:0] gnt_id_o,
  output logic                     busy_o
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, STREAM, PAD, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   gnt_nxt;
  logic [N_REQ-1:0] pick_req;
  logic [IDW-1:0]   pick_ptr;
  logic [IDW-1:0]   pick_id;
  logic             pick_found;

  assign gnt_nxt = IDW'((int'(gnt_q) + 1) % N_REQ);

  // At a block boundary the current owner's in-flight word must not win the
  // re-pick, so it is masked out and the scan starts just past it.
  assign pick_req = (state_q == IDLE) ? vld_i : (vld_i & ~(N_REQ'(1) << gnt_q));
  assign pick_ptr = (state_q == IDLE) ? ptr_q : gnt_nxt;

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .id    (pick_id),
    .found (pick_found)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rdy_o   = '0;
    data_o  = '0;
    vld_o   = 1'b0;
    flush_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_id;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        data_o       = data_i[gnt_q];
        vld_o        = vld_i[gnt_q];
        rdy_o[gnt_q] = rdy_i;
        if (vld_i[gnt_q] && rdy_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            ptr_d = gnt_nxt;
            if (last_i[gnt_q]) begin
              state_d = FLUSH;
            end else if (pick_found) begin
              gnt_d = pick_id;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (last_i[gnt_q]) begin
              ptr_d   = gnt_nxt;
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        vld_o = 1'b1;
        if (rdy_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (enc_idle_i) begin
          flush_o = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_id_o = gnt_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_dbx_enc_arb.sv
// Scoreboarded random/directed bench for dbx_enc_arb: per-source expected
// block streams (zero-padded) checked by an independent output monitor.
module tb_dbx_enc_arb;
  import ebpc_pkg::*;

  localparam int N = 2;

  typedef struct {
    logic signed [DATA_W-1:0] d;
    bit                       pad;
    bit                       eos;
  } exp_t;

  typedef struct {
    logic signed [DATA_W-1:0] d;
    bit                       last;
  } src_t;

  logic                     clk = 1'b0;
  logic                     rst_ni;
  logic signed [DATA_W-1:0] data_i [N];
  logic [N-1:0]             vld_i;
  logic [N-1:0]             last_i;
  logic [N-1:0]             rdy_o;
  logic signed [DATA_W-1:0] data_o;
  logic                     vld_o;
  logic                     rdy_i;
  logic                     flush_o;
  logic                     enc_idle_i;
  logic [$clog2(N)-1:0]     gnt_id_o;
  logic                     busy_o;

  dbx_enc_arb #(.N_REQ(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .vld_i      (vld_i),
    .last_i     (last_i),
    .rdy_o      (rdy_o),
    .data_o     (data_o),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .flush_o    (flush_o),
    .enc_idle_i (enc_idle_i),
    .gnt_id_o   (gnt_id_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  exp_t exp_q [N][$];
  src_t src_q [N][$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   flush_cnt = 0;
  int   pad_seen = 0;
  int   hs_total = 0;
  int   blk_src [$];
  int   wd_cyc [$];
  bit   flush_pending = 0;
  int   blk_cnt = 0;
  int   blk_gnt = 0;
  int   hold_low [N];
  int   gap_pct [N];
  bit   rnd_rdy = 0;
  bit   rnd_idle = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // A stream of len words becomes ceil(len/BLOCK_SIZE) blocks, tail zero-filled.
  task automatic send(input int r, input int len, input int base, input bit rnd);
    int   nblk;
    exp_t e;
    src_t s;
    nblk = (len + BLOCK_SIZE - 1) / BLOCK_SIZE;
    for (int i = 0; i < nblk * BLOCK_SIZE; i++) begin
      e.pad = (i >= len);
      e.eos = (i == nblk * BLOCK_SIZE - 1);
      if (i < len) e.d = rnd ? DATA_W'($urandom) : DATA_W'(base + i);
      else         e.d = '0;
      exp_q[r].push_back(e);
      if (i < len) begin
        s.d    = e.d;
        s.last = (i == len - 1);
        src_q[r].push_back(s);
      end
    end
  endtask

  task automatic src_proc(input int r);
    bit   acc;
    src_t s;
    forever begin
      @(negedge clk);
      acc = rst_ni && vld_i[r] && rdy_o[r];
      @(posedge clk);
      #1;
      if (acc && src_q[r].size() > 0) s = src_q[r].pop_front();
      if (hold_low[r] > 0) begin
        hold_low[r]--;
        vld_i[r]  = 1'b0;
        last_i[r] = 1'($urandom);
        data_i[r] = '0;
      end else if (src_q[r].size() > 0 && $urandom_range(0, 99) >= gap_pct[r]) begin
        vld_i[r]  = 1'b1;
        data_i[r] = src_q[r][0].d;
        last_i[r] = src_q[r][0].last;
      end else begin
        vld_i[r]  = 1'b0;
        last_i[r] = 1'($urandom);
        data_i[r] = '0;
      end
    end
  endtask

  task automatic env_proc();
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy)  rdy_i      = ($urandom_range(0, 3) != 0);
      if (rnd_idle) enc_idle_i = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic monitor();
    int   g;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) begin
        blk_cnt       = 0;
        flush_pending = 0;
      end else begin
        if (flush_pending) begin
          if (enc_idle_i) chk("flush_first_idle_cycle", flush_o, 1);
        end else begin
          chk("flush_spurious", flush_o, 0);
        end
        if (flush_o) begin
          flush_cnt++;
          chk("flush_with_idle", enc_idle_i, 1);
          chk("flush_vld_low", vld_o, 0);
          flush_pending = 0;
        end
        if (vld_o && rdy_i) begin
          hs_total++;
          wd_cyc.push_back(cyc);
          chk("busy_on_word", busy_o, 1);
          chk("word_before_flush", flush_pending, 0);
          g = int'(gnt_id_o);
          if (blk_cnt == 0) begin
            blk_gnt = g;
            blk_src.push_back(g);
          end else begin
            chk("gnt_stable_in_block", g, blk_gnt);
          end
          if (exp_q[g].size() == 0) begin
            chk("word_expected", exp_q[g].size(), 1);
          end else begin
            e = exp_q[g].pop_front();
            chk("data", data_o, e.d);
            if (e.pad) begin
              pad_seen++;
              chk("pad_rdy_low", rdy_o, 0);
            end else begin
              chk("rdy_route", rdy_o, N'(1) << g);
            end
            blk_cnt = (blk_cnt + 1) % BLOCK_SIZE;
            if (e.eos) begin
              chk("stream_ends_on_block", blk_cnt, 0);
              flush_pending = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 3000 && !(src_q[0].size() == 0 && src_q[1].size() == 0 &&
           exp_q[0].size() == 0 && exp_q[1].size() == 0 && !flush_pending && !busy_o)) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({name, "_completes"}, (n < 3000), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_words(input string name, input int k);
    int n;
    int h0;
    n  = 0;
    h0 = hs_total;
    while (hs_total < h0 + k && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_words_arrive"}, (n < 500), 1);
  endtask

  task automatic check_reset(input string p);
    chk({p, "_vld_o"}, vld_o, 0);
    chk({p, "_rdy_o"}, rdy_o, 0);
    chk({p, "_flush_o"}, flush_o, 0);
    chk({p, "_busy_o"}, busy_o, 0);
    chk({p, "_gnt_id_o"}, gnt_id_o, 0);
    chk({p, "_data_o"}, data_o, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int f0;
    int p0;
    int n;
    rst_ni     = 1'b0;
    vld_i      = '0;
    last_i     = '0;
    rdy_i      = 1'b1;
    enc_idle_i = 1'b1;
    for (int r = 0; r < N; r++) begin
      data_i[r]   = '0;
      hold_low[r] = 0;
      gap_pct[r]  = 0;
    end
    fork
      src_proc(0);
      src_proc(1);
      env_proc();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #2;
    check_reset("rst");
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #2;

    // Both continuously valid: alternating blocks, no bubbles.
    blk_src.delete();
    wd_cyc.delete();
    f0 = flush_cnt;
    send(0, 16, 10, 0);
    send(1, 16, 50, 0);
    wait_done("t2");
    chk("t2_block_count", blk_src.size(), 4);
    for (int i = 0; i < blk_src.size() && i < 4; i++) chk("t2_block_order", blk_src[i], i % 2);
    chk("t2_word_count", wd_cyc.size(), 32);
    if (wd_cyc.size() >= 24) chk("t2_no_bubbles", wd_cyc[23] - wd_cyc[0], 23);
    chk("t2_flushes", flush_cnt - f0, 2);

    // Requester 0 alone, two full blocks.
    blk_src.delete();
    f0 = flush_cnt;
    send(0, 16, 1, 0);
    wait_done("t1");
    chk("t1_block_count", blk_src.size(), 2);
    for (int i = 0; i < blk_src.size(); i++) chk("t1_gnt", blk_src[i], 0);
    chk("t1_flushes", flush_cnt - f0, 1);

    // Short stream from requester 1 is padded with five zeros.
    blk_src.delete();
    f0 = flush_cnt;
    p0 = pad_seen;
    send(1, 3, 7, 0);
    wait_done("t3");
    chk("t3_pad_words", pad_seen - p0, 5);
    chk("t3_flushes", flush_cnt - f0, 1);
    if (blk_src.size() > 0) chk("t3_gnt", blk_src[0], 1);

    // Exact block, encoder busy for five cycles before accepting the flush.
    f0 = flush_cnt;
    p0 = pad_seen;
    enc_idle_i = 1'b0;
    send(0, 8, 100, 0);
    n = 0;
    while (exp_q[0].size() > 0 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t5_block_sent", (n < 500), 1);
    repeat (5) @(posedge clk);
    #2;
    chk("t5_no_flush_while_busy", flush_cnt - f0, 0);
    chk("t5_busy_waiting", busy_o, 1);
    enc_idle_i = 1'b1;
    wait_done("t5");
    chk("t5_flushes", flush_cnt - f0, 1);
    chk("t5_no_pad", pad_seen - p0, 0);

    // Backpressure and a mid-block valid drop while requester 1 waits.
    blk_src.delete();
    rnd_rdy = 1;
    send(0, 20, 0, 1);
    wait_words("t4", 3);
    hold_low[0] = 4;
    send(1, 12, 0, 1);
    wait_done("t4");
    if (blk_src.size() > 0) chk("t4_first_block_owner", blk_src[0], 0);

    // Random traffic, random backpressure and encoder-idle.
    rnd_idle = 1;
    for (int round = 0; round < 8; round++) begin
      for (int r = 0; r < N; r++) begin
        gap_pct[r] = $urandom_range(0, 40);
        if ($urandom_range(0, 3) != 0) send(r, $urandom_range(1, 20), 0, 1);
      end
      wait_done("rand");
    end
    rnd_rdy  = 0;
    rnd_idle = 0;
    rdy_i      = 1'b1;
    enc_idle_i = 1'b1;
    for (int r = 0; r < N; r++) gap_pct[r] = 0;

    // Move the pointer past requester 0, then reset mid-block.
    send(0, 3, 1, 0);
    wait_done("t6_pre");
    send(0, 10, 30, 0);
    wait_words("t6", 3);
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    for (int r = 0; r < N; r++) begin
      src_q[r].delete();
      exp_q[r].delete();
      hold_low[r] = 0;
    end
    vld_i  = '0;
    last_i = '0;
    #1;
    check_reset("t6_rst");
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
    @(posedge clk);
    #2;
    blk_src.delete();
    send(0, 8, 40, 0);
    send(1, 8, 60, 0);
    wait_done("t6");
    chk("t6_block_count", blk_src.size(), 2);
    if (blk_src.size() > 0) chk("t6_first_gnt_after_reset", blk_src[0], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
